pixel_streamer: RTL and testbench
=================================

Name: pixel_streamer

Overview:
- Source end of the raster pixel interface that feeds the `window` line-buffer block on its `start`/`din`/`state` inputs.
- Reads one IMG_W x IMG_H 8-bit image from a synchronous frame-buffer RAM (1-cycle read latency) in raster order.
- Emits the image as a valid/ready pixel stream with row/frame markers.
- Replaces file-driven stimulus as the on-chip image source for the BNN datapath.

Parameters:
- IMG_W, 28, pixels per row
- IMG_H, 28, rows per frame
- PIX_W, 8, pixel width in bits
- ADDR_W, 10, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- go  in  1  frame request; sampled only in IDLE
- mem_rd_en  out  1  frame-buffer read strobe
- mem_addr  out  ADDR_W  frame-buffer read address
- mem_rdata  in  PIX_W  read data, valid the cycle after mem_rd_en
- out_ready  in  1  downstream can accept a pixel this cycle
- start  out  1  level, high from go acceptance until done; drives `window.start`
- din  out  PIX_W  pixel data; drives `window.din`
- state  out  1  pixel valid qualifier; drives `window.state`
- eol  out  1  current pixel is last in its row; qualified by state
- eof  out  1  current pixel is last in frame; qualified by state
- done  out  1  one-cycle pulse after the last pixel transfers

Behaviour:
- Reset (async assert, sync release): every output is 0, the FSM is IDLE, counters are 0, and the buffer is empty. Reset mid-frame aborts the frame with no done pulse.
- A pixel transfer occurs on a rising edge where state && out_ready are both high.
- Once state is high, din/eol/eof hold stable until the transfer completes.
- FSM:
  - IDLE: go=1 -> FETCH, start<=1, read address counter <= 0.
  - FETCH: asserts mem_rd_en with mem_addr = counter when the buffer has room (entries held + reads in flight < 2), then increments the counter. After address IMG_W*IMG_H-1 is issued -> DRAIN.
  - DRAIN: waits until the last pixel (eof) transfers -> DONE.
  - DONE: done=1 and start<=0 for one cycle -> IDLE.
- go is ignored outside IDLE.
- Latency, with out_ready held high and go accepted at edge 0:
  - mem_rd_en/addr 0 at cycle 1.
  - state=1 with pixel 0 at cycle 3.
  - One pixel per cycle, no bubbles: the last pixel is at cycle 3+IMG_W*IMG_H-1 (786 by default).
  - done at cycle 787.
- Buffering: read data returns into a 2-entry skid FIFO, so no read is ever lost or duplicated when out_ready drops while data is in flight. The output is driven from the FIFO head; state = FIFO not empty.
- Column/row counters advance on output transfers, not on reads:
  - eol = (col == IMG_W-1).
  - eof = eol && (row == IMG_H-1).
  - col wraps to 0 on eol; row wraps to 0 on eof.
- Address arithmetic is unsigned ADDR_W-bit and never exceeds IMG_W*IMG_H-1.
- Simultaneous FIFO push and pop with one entry held keeps the count unchanged.
- out_ready low for any duration must not change the pixel order or count.

Decomposition:
- Shared package `bnn_img_pkg`:
  - constants IMG_W, IMG_H, PIX_W, FRAME_PIX = IMG_W*IMG_H.
  - the FSM state encoding (IDLE, FETCH, DRAIN, DONE).
- One sub-module, `pixel_skid_fifo`:
  - 2-entry, PIX_W wide, with push, pop, head, count.
  - resets asynchronously via rst_n.

Test Plan:
1. Reset then go pulse, out_ready=1, RAM[i]=i mod 256 -> start rises at cycle 1; din = 0,1,2,... from cycle 3 for 784 consecutive cycles. eol is high on pixels 27, 55, ...; eof only on pixel 783 (din=15). done is high at cycle 787, then start falls.
2. out_ready toggled 1,0,0,1 pseudo-randomly during the frame -> exactly 784 transfers in order 0..783, din stable while state=1 && out_ready=0, mem_rd_en never issued with 2 entries outstanding.
3. go held high continuously -> frames run back-to-back with one IDLE cycle between done and the next start rise; no go accepted mid-frame.
4. rst_n asserted at pixel 400, then released and go pulsed -> all outputs 0 immediately on assertion, no done pulse; the next frame restarts at address 0 with row=col=0.
5. out_ready=0 from go onward for 20 cycles, then 1 -> exactly 2 reads issued before stall, first transfer is pixel 0, and the remaining stream is gap-free.
6. Parameter override IMG_W=4, IMG_H=3 -> 12 pixels, eol on pixels 3, 7, 11, eof on pixel 11, done 12 cycles after the first valid.

Source files
------------

// File: rtl/bnn_img_pkg.sv
// Shared image geometry and streamer FSM encoding for the BNN image source.
package bnn_img_pkg;

  localparam int unsigned IMG_W     = 28;
  localparam int unsigned IMG_H     = 28;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned FRAME_PIX = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } strm_state_e;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry skid FIFO catching frame-buffer read data; head is registered.
module pixel_skid_fifo #(
  parameter int unsigned WIDTH = bnn_img_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;

  // Pop shifts tail into head; push lands in the first free slot after the pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop_i && (cnt_q != 2'd0)) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (push_i) begin
      if (cnt_d == 2'd0) begin
        head_d = wdata_i;
      end else begin
        tail_d = wdata_i;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/pixel_streamer.sv
// Reads one frame from a 1-cycle-latency RAM in raster order and streams it
// out as valid/ready pixels with end-of-row / end-of-frame markers.
module pixel_streamer #(
  parameter int unsigned IMG_W  = bnn_img_pkg::IMG_W,
  parameter int unsigned IMG_H  = bnn_img_pkg::IMG_H,
  parameter int unsigned PIX_W  = bnn_img_pkg::PIX_W,
  parameter int unsigned ADDR_W = bnn_img_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  input  logic              out_ready,
  output logic              start,
  output logic [PIX_W-1:0]  din,
  output logic              state,
  output logic              eol,
  output logic              eof,
  output logic              done
);

  import bnn_img_pkg::*;

  localparam int unsigned FRAME = IMG_W * IMG_H;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_H - 1);

  strm_state_e       fsm_q, fsm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              rd_pend_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;

  logic              rd_en_c;
  logic [1:0]        fifo_cnt;
  logic [PIX_W-1:0]  fifo_head;
  logic              valid_c;
  logic              xfer_c;
  logic              eol_c;
  logic              eof_c;
  logic [2:0]        occ_after_c;
  logic              room_c;

  assign valid_c     = (fifo_cnt != 2'd0);
  assign xfer_c      = valid_c && out_ready;
  assign eol_c       = valid_c && (col_q == LAST_COL);
  assign eof_c       = eol_c && (row_q == LAST_ROW);
  // A read may issue if, after this cycle's pop, held + in-flight + it fit in 2.
  assign occ_after_c = 3'(fifo_cnt) + 3'(rd_pend_q) - 3'(xfer_c);
  assign room_c      = (occ_after_c < 3'd2);

  pixel_skid_fifo #(
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_pend_q),
    .wdata_i (mem_rdata),
    .pop_i   (xfer_c),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  // Frame sequencing: address issue, frame start level and done pulse.
  always_comb begin
    fsm_d   = fsm_q;
    addr_d  = addr_q;
    start_d = start_q;
    done_d  = 1'b0;
    rd_en_c = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (go) begin
          fsm_d   = ST_FETCH;
          start_d = 1'b1;
          addr_d  = '0;
        end
      end
      ST_FETCH: begin
        if (room_c) begin
          rd_en_c = 1'b1;
          if (addr_q == LAST_ADDR) begin
            fsm_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (xfer_c && eof_c) begin
          fsm_d  = ST_DONE;
          done_d = 1'b1;
        end
      end
      ST_DONE: begin
        fsm_d   = ST_IDLE;
        start_d = 1'b0;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  // Raster position of the pixel at the FIFO head; advances on transfers only.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (xfer_c) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // State, counters and the read-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= ST_IDLE;
      addr_q    <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      fsm_q     <= fsm_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      done_q    <= done_d;
      rd_pend_q <= rd_en_c;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  assign mem_rd_en = rd_en_c;
  assign mem_addr  = addr_q;
  assign start     = start_q;
  assign done      = done_q;
  assign din       = fifo_head;
  assign state     = valid_c;
  assign eol       = eol_c;
  assign eof       = eof_c;

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer: a raster reference model fills an
// expected-beat queue per frame, a monitor pops it on every transfer.
module tb_pixel_streamer;

  localparam int unsigned W  = 28;
  localparam int unsigned H  = 28;
  localparam int unsigned N  = W * H;
  localparam int unsigned SW = 4;
  localparam int unsigned SH = 3;
  localparam int unsigned SN = SW * SH;

  typedef struct packed {
    logic [7:0] pix;
    logic       eol;
    logic       eof;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       go;
  logic       out_ready;
  logic       mem_rd_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       start, state, eol, eof, done;
  logic [7:0] din;

  logic       s_go;
  logic       s_ready;
  logic       s_rd_en;
  logic [3:0] s_addr;
  logic [7:0] s_rdata;
  logic       s_start, s_state, s_eol, s_eof, s_done;
  logic [7:0] s_din;

  logic [7:0] ram   [0:1023];
  logic [7:0] s_ram [0:15];

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_xfer   = 0;
  int    ready_mode = 0;

  pixel_streamer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_ready (out_ready),
    .start     (start),
    .din       (din),
    .state     (state),
    .eol       (eol),
    .eof       (eof),
    .done      (done)
  );

  pixel_streamer #(.IMG_W(SW), .IMG_H(SH), .PIX_W(8), .ADDR_W(4)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (s_go),
    .mem_rd_en (s_rd_en),
    .mem_addr  (s_addr),
    .mem_rdata (s_rdata),
    .out_ready (s_ready),
    .start     (s_start),
    .din       (s_din),
    .state     (s_state),
    .eol       (s_eol),
    .eof       (s_eof),
    .done      (s_done)
  );

  always #5 clk = ~clk;

  // Synchronous frame-buffer models, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
    if (s_rd_en)   s_rdata   <= s_ram[s_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: raster order, marker positions from index arithmetic.
  task automatic push_frame();
    for (int i = 0; i < int'(N); i++) begin
      beat_t b;
      b.pix = ram[i];
      b.eol = ((i % W) == W - 1);
      b.eof = (i == N - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(N); i++) ram[i] = 8'($urandom);
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  task automatic run_to_done(input int start_cyc, input int budget, output int cyc);
    cyc = start_cyc;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) return;
    end
    cyc = -1;
  endtask

  // Downstream ready pattern, updated just after each rising edge.
  initial begin : ready_drv
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: transfer ordering, hold stability, done timing, read outstanding bound.
  initial begin : monitor
    bit    held;
    beat_t held_b;
    beat_t want;
    bit    done_due;
    bit    prev_x;
    int    outst;
    held = 0; done_due = 0; prev_x = 0; outst = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        held = 0; done_due = 0; prev_x = 0; outst = 0;
        continue;
      end
      check("done_pulse", 32'(done), 32'(done_due));
      done_due = 0;
      if (mem_rd_en) outst++;
      if (held) check("hold_stable", 32'({state, din, eol, eof}), 32'({1'b1, held_b}));
      if (prev_x && ready_mode == 0) check("no_bubble", 32'(state), 32'd1);
      prev_x = 0;
      if (state && out_ready) begin
        outst--;
        held = 0;
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pixel: got din %0h with no pixel expected at %0t", din, $time);
        end else begin
          want = exp_q.pop_front();
          check("pixel_beat", 32'({din, eol, eof}), 32'(want));
          done_due = want.eof;
          prev_x   = !want.eof;
        end
      end else if (state) begin
        held   = 1;
        held_b = {din, eol, eof};
      end else begin
        held = 0;
      end
      check("reads_outstanding_le2", 32'(outst > 2), 32'd0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int cyc, base, rises, dones, dcyc, reads, idx, first_cyc;
    bit prev_start;
    rst_n = 1'b0; go = 1'b0; s_go = 1'b0; s_ready = 1'b1;
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i % 256);
    for (int i = 0; i < 16; i++) s_ram[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_start", 32'(start), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_din",   32'(din), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame with RAM[i] = i mod 256, ready always high: latency and markers.
    ready_mode = 0;
    push_frame();
    pulse_go();
    @(negedge clk);
    check("c1_start", 32'(start), 32'd1);
    check("c1_rd_en", 32'(mem_rd_en), 32'd1);
    check("c1_addr",  32'(mem_addr), 32'd0);
    @(negedge clk);
    check("c2_state", 32'(state), 32'd0);
    @(negedge clk);
    check("c3_state", 32'(state), 32'd1);
    check("c3_din",   32'(din), 32'd0);
    run_to_done(3, N + 50, cyc);
    check("done_cycle", 32'(cyc), 32'd787);
    @(negedge clk);
    check("start_fall", 32'(start), 32'd0);
    check("queue_empty_1", 32'(exp_q.size()), 32'd0);

    // Random data with random backpressure.
    fill_random();
    ready_mode = 1;
    push_frame();
    pulse_go();
    run_to_done(0, 8 * N, cyc);
    check("rand_done_seen", 32'(cyc > 0), 32'd1);
    ready_mode = 0;
    repeat (2) @(negedge clk);
    check("queue_empty_2", 32'(exp_q.size()), 32'd0);

    // go held high: two back-to-back frames with one idle cycle between.
    fill_random();
    push_frame();
    push_frame();
    @(negedge clk);
    go = 1'b1;
    rises = 0; dones = 0; dcyc = 0; cyc = 0; prev_start = start;
    for (int k = 0; k < 3 * int'(N); k++) begin
      @(negedge clk);
      cyc++;
      if (start && !prev_start) begin
        rises++;
        if (dones == 1) check("b2b_gap", 32'(cyc - dcyc), 32'd2);
      end
      prev_start = start;
      if (done) begin
        dones++;
        dcyc = cyc;
        if (dones == 2) begin
          go = 1'b0;
          break;
        end
      end
    end
    check("b2b_dones", 32'(dones), 32'd2);
    check("b2b_rises", 32'(rises), 32'd2);
    repeat (5) @(negedge clk);
    check("b2b_idle_start", 32'(start), 32'd0);
    check("queue_empty_3", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame at pixel 400, then a clean restart from address 0.
    fill_random();
    push_frame();
    base = n_xfer;
    pulse_go();
    for (int k = 0; k < 2000 && (n_xfer - base) < 400; k++) @(negedge clk);
    check("reached_400", 32'(n_xfer - base), 32'd400);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", 32'({start, state, eol, eof, done, mem_rd_en}), 32'd0);
    check("abort_din", 32'(din), 32'd0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push_frame();
    pulse_go();
    run_to_done(0, N + 50, cyc);
    check("restart_done_cycle", 32'(cyc), 32'd787);
    repeat (2) @(negedge clk);
    check("queue_empty_4", 32'(exp_q.size()), 32'd0);

    // Downstream stalled for 20 cycles from go: only two reads may issue.
    fill_random();
    push_frame();
    ready_mode = 2;
    pulse_go();
    reads = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_rd_en) reads++;
    end
    check("stall_reads", 32'(reads), 32'd2);
    check("stall_head", 32'({state, din}), 32'({1'b1, ram[0]}));
    ready_mode = 0;
    run_to_done(20, N + 50, cyc);
    check("stall_done_cycle", 32'(cyc), 32'd805);
    repeat (2) @(negedge clk);
    check("queue_empty_5", 32'(exp_q.size()), 32'd0);

    // Small 4x3 instance: markers, count and done latency.
    @(negedge clk);
    s_go = 1'b1;
    @(posedge clk);
    #1 s_go = 1'b0;
    idx = 0; first_cyc = -1; cyc = 0; dcyc = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      cyc++;
      if (s_state) begin
        if (first_cyc < 0) first_cyc = cyc;
        check("small_beat", 32'({s_din, s_eol, s_eof}),
              32'({s_ram[idx], 1'((idx % SW) == SW - 1), 1'(idx == SN - 1)}));
        idx++;
      end
      if (s_done) begin
        dcyc = cyc;
        break;
      end
    end
    check("small_count", 32'(idx), 32'(SN));
    check("small_first", 32'(first_cyc), 32'd3);
    check("small_done_lat", 32'(dcyc - first_cyc), 32'(SN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
